// File: rtl/br_flow_upsizer.sv
// br_flow_upsizer: packs Ratio narrow ready/valid beats into one registered wide word, lane 0 first.
// Optional feature macro: BR_FLOW_UPSIZER_WORD_COUNT_EN adds the pop_word_count output.
module br_flow_upsizer #(
    parameter int Width      = 1,
    parameter int Ratio      = 2,
    parameter int CountWidth = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       push_ready,
    input  logic                       push_valid,
    input  logic [Width-1:0]           push_data,
    input  logic                       push_last,
    input  logic                       pop_ready,
    output logic                       pop_valid,
    output logic [Width*Ratio-1:0]     pop_data,
    output logic [$clog2(Ratio+1)-1:0] pop_beats,
    output logic                       pop_last
`ifdef BR_FLOW_UPSIZER_WORD_COUNT_EN
    ,
    output logic [CountWidth-1:0]      pop_word_count
`endif
);

    localparam int IdxWidth   = $clog2(Ratio);
    localparam int BeatsWidth = $clog2(Ratio + 1);

    if (Width < 1) begin : g_bad_width
        $error("br_flow_upsizer: Width must be >= 1");
    end
    if (Ratio < 2) begin : g_bad_ratio
        $error("br_flow_upsizer: Ratio must be >= 2");
    end
    if (CountWidth < 1) begin : g_bad_count_width
        $error("br_flow_upsizer: CountWidth must be >= 1");
    end

    logic [IdxWidth-1:0]    idx;
    logic                   push_hs;
    logic                   pop_hs;
    logic                   closes;
    logic                   clear_others;
    logic [Width*Ratio-1:0] lanes_next;

    // A held word blocks new beats only while downstream is stalling it.
    assign push_ready   = !pop_valid || pop_ready;
    assign push_hs      = push_valid && push_ready;
    assign pop_hs       = pop_valid && pop_ready;
    assign closes       = push_last || (idx == IdxWidth'(Ratio - 1));
    assign clear_others = pop_hs || (idx == '0);

    // Starting a new word zeroes every other lane so partial words read 0 above the last beat.
    always_comb begin
        lanes_next = pop_data;
        for (int i = 0; i < Ratio; i++) begin
            if (push_hs) begin
                if (IdxWidth'(i) == idx) begin
                    lanes_next[i*Width +: Width] = push_data;
                end else if (clear_others) begin
                    lanes_next[i*Width +: Width] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_data  <= '0;
            pop_valid <= 1'b0;
            pop_beats <= '0;
            pop_last  <= 1'b0;
            idx       <= '0;
        end else begin
            pop_data <= lanes_next;
            if (push_hs && closes) begin
                pop_valid <= 1'b1;
                pop_beats <= BeatsWidth'(idx) + BeatsWidth'(1);
                pop_last  <= push_last;
                idx       <= '0;
            end else begin
                if (pop_ready) begin
                    pop_valid <= 1'b0;
                end
                if (push_hs) begin
                    idx <= idx + IdxWidth'(1);
                end
            end
        end
    end

`ifdef BR_FLOW_UPSIZER_WORD_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_word_count <= '0;
        end else if (pop_hs) begin
            pop_word_count <= pop_word_count + CountWidth'(1);
        end
    end
`endif

`ifndef SYNTHESIS
    // Previous-cycle snapshots for the stability checks on both interfaces.
    logic                   chk_pop_hold_q;
    logic [Width*Ratio-1:0] chk_pop_data_q;
    logic [BeatsWidth-1:0]  chk_pop_beats_q;
    logic                   chk_pop_last_q;
    logic                   chk_push_hold_q;
    logic [Width-1:0]       chk_push_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_pop_hold_q  <= 1'b0;
            chk_push_hold_q <= 1'b0;
        end else begin
            chk_pop_hold_q  <= pop_valid && !pop_ready;
            chk_push_hold_q <= push_valid && !push_ready;
        end
        chk_pop_data_q  <= pop_data;
        chk_pop_beats_q <= pop_beats;
        chk_pop_last_q  <= pop_last;
        chk_push_data_q <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (chk_pop_hold_q) begin
                assert (pop_data == chk_pop_data_q && pop_beats == chk_pop_beats_q &&
                        pop_last == chk_pop_last_q);
            end
            if (chk_push_hold_q) begin
                assert (push_valid && push_data == chk_push_data_q);
            end
            if (pop_valid) begin
                assert (pop_beats != '0 && pop_beats <= BeatsWidth'(Ratio));
            end
        end
    end
`endif

endmodule

// File: tb/tb_br_flow_upsizer.sv
// Directed self-checking bench for br_flow_upsizer with Width=8, Ratio=4.
// Word-count checks compile in when BR_FLOW_UPSIZER_WORD_COUNT_EN is defined.
module tb_br_flow_upsizer;

    localparam int Width      = 8;
    localparam int Ratio      = 4;
    localparam int CountWidth = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       push_ready;
    logic                       push_valid;
    logic [Width-1:0]           push_data;
    logic                       push_last;
    logic                       pop_ready;
    logic                       pop_valid;
    logic [Width*Ratio-1:0]     pop_data;
    logic [$clog2(Ratio+1)-1:0] pop_beats;
    logic                       pop_last;
`ifdef BR_FLOW_UPSIZER_WORD_COUNT_EN
    logic [CountWidth-1:0]      pop_word_count;
    logic [CountWidth-1:0]      exp_count [5];
`endif

    int errors = 0;
    int checks = 0;
    int stalls;
    int words;
    logic [31:0] exp_word;

    always #5 clk = ~clk;

    br_flow_upsizer #(
        .Width(Width),
        .Ratio(Ratio),
        .CountWidth(CountWidth)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push_ready(push_ready),
        .push_valid(push_valid),
        .push_data(push_data),
        .push_last(push_last),
        .pop_ready(pop_ready),
        .pop_valid(pop_valid),
        .pop_data(pop_data),
        .pop_beats(pop_beats),
        .pop_last(pop_last)
`ifdef BR_FLOW_UPSIZER_WORD_COUNT_EN
        ,
        .pop_word_count(pop_word_count)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic pr);
        push_valid = v;
        push_data  = d;
        push_last  = l;
        pop_ready  = pr;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        tick;
        tick;
        rst = 1'b0;
        #1;
        checkOutput("reset_pop_valid", pop_valid, 0);
        checkOutput("reset_pop_data", pop_data, 0);
        checkOutput("reset_pop_beats", pop_beats, 0);
        checkOutput("reset_pop_last", pop_last, 0);
        checkOutput("reset_push_ready", push_ready, 1);

        $display("[TB] full word 11,22,33,44");
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b1); tick;
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b1); tick;
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1); tick;
        checkOutput("full_not_yet_valid", pop_valid, 0);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b1); tick;
        checkOutput("full_valid", pop_valid, 1);
        checkOutput("full_data", pop_data, 64'h44332211);
        checkOutput("full_beats", pop_beats, 4);
        checkOutput("full_last", pop_last, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1); tick;
        checkOutput("full_drained", pop_valid, 0);

        $display("[TB] partial word AA,BB(last)");
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1); tick;
        checkOutput("partial_not_yet_valid", pop_valid, 0);
        applyStimulus(1'b1, 8'hBB, 1'b1, 1'b1); tick;
        checkOutput("partial_valid", pop_valid, 1);
        checkOutput("partial_data", pop_data, 64'h0000BBAA);
        checkOutput("partial_beats", pop_beats, 2);
        checkOutput("partial_last", pop_last, 1);
        applyStimulus(1'b1, 8'hCC, 1'b0, 1'b1);
        #1;
        checkOutput("partial_next_push_ready", push_ready, 1);
        tick;
        checkOutput("next_word_valid", pop_valid, 0);
        checkOutput("next_word_lane0", pop_data, 64'h000000CC);
        applyStimulus(1'b1, 8'hDD, 1'b0, 1'b1); tick;
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1); tick;
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1); tick;
        checkOutput("next_word_data", pop_data, 64'hFFEEDDCC);
        checkOutput("next_word_valid_full", pop_valid, 1);

        $display("[TB] backpressure hold");
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput("hold_push_ready", push_ready, 0);
            checkOutput("hold_pop_valid", pop_valid, 1);
            checkOutput("hold_pop_data", pop_data, 64'hFFEEDDCC);
            checkOutput("hold_pop_beats", pop_beats, 4);
            checkOutput("hold_pop_last", pop_last, 0);
            tick;
        end
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b1);
        #1;
        checkOutput("release_push_ready", push_ready, 1);
        tick;
        checkOutput("release_pop_valid", pop_valid, 0);
        checkOutput("release_lane0", pop_data, 64'h00000010);
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b1); tick;
        applyStimulus(1'b1, 8'h30, 1'b0, 1'b1); tick;
        applyStimulus(1'b1, 8'h40, 1'b1, 1'b1); tick;
        checkOutput("last_at_full_valid", pop_valid, 1);
        checkOutput("last_at_full_data", pop_data, 64'h40302010);
        checkOutput("last_at_full_beats", pop_beats, 4);
        checkOutput("last_at_full_last", pop_last, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1); tick;
        checkOutput("last_at_full_drained", pop_valid, 0);

        $display("[TB] 400-beat stream");
        stalls = 0;
        words  = 0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
            #1;
            if (push_ready !== 1'b1) stalls++;
            tick;
            if (i % 4 == 3) begin
                exp_word = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
                checkOutput("stream_word", {31'd0, pop_valid, pop_data}, {31'd0, 1'b1, exp_word});
                if (pop_valid === 1'b1) words++;
            end
        end
        checkOutput("stream_stalls", stalls, 0);
        checkOutput("stream_words", words, 100);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1); tick;

        $display("[TB] reset mid-word");
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b1); tick;
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b1); tick;
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick;
        rst = 1'b0;
        checkOutput("midreset_pop_valid", pop_valid, 0);
        checkOutput("midreset_pop_data", pop_data, 0);
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b1); tick;
        applyStimulus(1'b1, 8'h06, 1'b0, 1'b1); tick;
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b1); tick;
        applyStimulus(1'b1, 8'h08, 1'b0, 1'b1); tick;
        checkOutput("postreset_valid", pop_valid, 1);
        checkOutput("postreset_data", pop_data, 64'h08070605);
        checkOutput("postreset_beats", pop_beats, 4);
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b1); tick;
        checkOutput("single_beat_valid", pop_valid, 1);
        checkOutput("single_beat_data", pop_data, 64'h000000AA);
        checkOutput("single_beat_beats", pop_beats, 1);
        checkOutput("single_beat_last", pop_last, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1); tick;

        $display("[TB] word counting");
`ifdef BR_FLOW_UPSIZER_WORD_COUNT_EN
        exp_count[0] = 2'd1;
        exp_count[1] = 2'd2;
        exp_count[2] = 2'd3;
        exp_count[3] = 2'd0;
        exp_count[4] = 2'd1;
`endif
        rst = 1'b1;
        tick;
        rst = 1'b0;
`ifdef BR_FLOW_UPSIZER_WORD_COUNT_EN
        checkOutput("count_reset", pop_word_count, 0);
`endif
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 8'(k + 1), 1'b1, 1'b1); tick;
            checkOutput("count_word_data", {31'd0, pop_valid, pop_data}, {31'd0, 1'b1, 24'd0, 8'(k + 1)});
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1); tick;
`ifdef BR_FLOW_UPSIZER_WORD_COUNT_EN
            checkOutput("count_value", pop_word_count, exp_count[k]);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
